// File: rtl/load_data_align_buf_if.sv
// Load-return aligner bus: request side (raw word + descriptor) and result side
// (aligned data + tag + error), each with its own valid/ready handshake.
interface load_data_align_buf_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    localparam int OFF_W = $clog2(DATA_W/8);

    logic              in_valid;
    logic              in_ready;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic              in_signed;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] in_raw;
    logic [DATA_W-1:0] in_ref;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport slave (
        input  in_valid, in_off, in_size, in_signed, in_mode, in_raw, in_ref, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

    modport master (
        output in_valid, in_off, in_size, in_signed, in_mode, in_raw, in_ref, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/load_data_align_buf.sv
// Memory-stage load aligner: lane extract, sign/zero extend, LWL/LWR-style merge,
// alignment error detect, then a 2-entry FIFO so writeback stalls never drop a load.
module load_data_align_buf #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8),
    parameter int TAG_W  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    load_data_align_buf_if.slave bus
);
    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } entry_t;

    // Mask covering the low nbytes bytes; a shift of the full width yields all ones.
    function automatic logic [DATA_W-1:0] low_mask(input logic [3:0] nbytes);
        low_mask = ~({DATA_W{1'b1}} << {nbytes, 3'b000});
    endfunction

    logic [3:0]        n_b, nm1_b, base_b, o_b, sh_b;
    logic [DATA_W-1:0] wmask, win, res, msb_mask;
    logic              sign, ext, err;
    entry_t            new_e;

    always_comb begin
        n_b    = 4'd1 << bus.in_size;
        nm1_b  = ~(4'hF << bus.in_size);
        base_b = 4'(bus.in_off) & ~nm1_b;
        o_b    = 4'(bus.in_off) & nm1_b;
        sh_b   = nm1_b ^ o_b;
        wmask  = low_mask(n_b);
        win    = (bus.in_raw >> {base_b, 3'b000}) & wmask;
        msb_mask = wmask ^ (wmask >> 1);
        res    = win;
        ext    = 1'b0;
        err    = 1'b0;
        case (bus.in_mode)
            MODE_NORMAL: begin
                err = (o_b != 4'd0);
                ext = bus.in_signed;
            end
            MODE_LEFT: begin
                err = (bus.in_size < 2'd2);
                res = ((win << {sh_b, 3'b000}) & wmask) | (bus.in_ref & low_mask(sh_b));
                ext = 1'b1;
            end
            MODE_RIGHT: begin
                err = (bus.in_size < 2'd2);
                res = (win >> {o_b, 3'b000}) | (bus.in_ref & wmask & ~(wmask >> {o_b, 3'b000}));
                ext = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (DATA_W == 32 && bus.in_size == 2'd3) err = 1'b1;
        // Merge results are always widened from the window msb; ~wmask is empty at full width.
        sign = |(res & msb_mask);
        if (ext && sign) res = res | ~wmask;
        new_e.data = err ? '0 : res;
        new_e.tag  = bus.in_tag;
        new_e.err  = err;
    end

    entry_t     head_q, head_d, tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = head_q.data;
    assign bus.out_tag   = head_q.tag;
    assign bus.out_err   = head_q.err;

    always_comb begin
        push    = bus.in_valid && bus.in_ready;
        pop     = bus.out_valid && bus.out_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: if (push) begin
                    head_d  = new_e;
                    count_d = 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = new_e;
                    end else if (push) begin
                        tail_d  = new_e;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule
